// File: rtl/multi_master_cmd_processor_if.sv
// multi_master_cmd_processor_if: bundle of per-lane bus master signals.
// Lane i occupies slice i of every packed field.
interface multi_master_cmd_processor_if #(
    parameter int NUM_MASTERS = 2,
    parameter int SLAVE_LEN   = 2,
    parameter int ADDR_LEN    = 12,
    parameter int DATA_LEN    = 8,
    parameter int BURST_LEN   = 12
);
    logic [NUM_MASTERS*ADDR_LEN-1:0]  address_m;
    logic [NUM_MASTERS*DATA_LEN-1:0]  data_m;
    logic [NUM_MASTERS*BURST_LEN-1:0] burst_num_m;
    logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_select_m;
    logic [2*NUM_MASTERS-1:0]         instruction_m;
    logic [NUM_MASTERS-1:0]           tx_done_m;
    logic [NUM_MASTERS-1:0]           rx_done_m;
    logic [NUM_MASTERS-1:0]           new_rx_m;
    logic [NUM_MASTERS*DATA_LEN-1:0]  new_data_m;

    modport master (
        output address_m, data_m, burst_num_m,
        output slave_select_m, instruction_m,
        input  tx_done_m, rx_done_m, new_rx_m, new_data_m
    );

    modport slave (
        input  address_m, data_m, burst_num_m,
        input  slave_select_m, instruction_m,
        output tx_done_m, rx_done_m, new_rx_m, new_data_m
    );
endinterface

// File: rtl/multi_master_cmd_processor.sv
// multi_master_cmd_processor: board switches/buttons to bus transactions.
// One lane active at a time; abort, timeout and read capture included.
module multi_master_cmd_processor #(
    parameter int NUM_MASTERS = 2,
    parameter int MSEL_LEN    = 2,
    parameter int SLAVE_LEN   = 2,
    parameter int ADDR_LEN    = 12,
    parameter int DATA_LEN    = 8,
    parameter int BURST_LEN   = 12,
    parameter int TIMEOUT     = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_LEN-1:0]  addr_sw,
    input  logic [DATA_LEN-1:0]  data_sw,
    input  logic [BURST_LEN-1:0] burst_sw,
    input  logic [SLAVE_LEN-1:0] slave_sw,
    input  logic                 rw_sw,
    input  logic [MSEL_LEN-1:0]  master_sw,
    input  logic                 button_go,
    input  logic                 button_abort,
    multi_master_cmd_processor_if.master bus,
    output logic [DATA_LEN-1:0]  read_data,
    output logic [BURST_LEN-1:0] read_count,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err_code
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t state;
    logic [MSEL_LEN-1:0] cmd_m;
    logic [TW-1:0]       tcnt;

    logic go_meta, go_sync, go_prev;
    logic ab_meta, ab_sync, ab_prev;
    logic go_pulse, abort_pulse;

    logic [NUM_MASTERS-1:0]           sw_sel, sel;
    logic [NUM_MASTERS*ADDR_LEN-1:0]  addr_n;
    logic [NUM_MASTERS*DATA_LEN-1:0]  data_n;
    logic [NUM_MASTERS*BURST_LEN-1:0] burst_n;
    logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_n;
    logic [2*NUM_MASTERS-1:0]         instr_n;
    logic [BURST_LEN-1:0]             burst_fix;
    logic [DATA_LEN-1:0]              lane_word;
    logic lane_tx, lane_rx, lane_new, lane_fin, bad_sw;

    // Synchronise both buttons and keep the previous value for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            go_meta <= 1'b0;
            go_sync <= 1'b0;
            go_prev <= 1'b0;
            ab_meta <= 1'b0;
            ab_sync <= 1'b0;
            ab_prev <= 1'b0;
        end else begin
            go_meta <= button_go;
            go_sync <= go_meta;
            go_prev <= go_sync;
            ab_meta <= button_abort;
            ab_sync <= ab_meta;
            ab_prev <= ab_sync;
        end
    end

    assign go_pulse    = go_sync & ~go_prev;
    assign abort_pulse = ab_sync & ~ab_prev;
    assign bad_sw      = int'(master_sw) >= NUM_MASTERS;
    assign burst_fix   = (burst_sw == '0) ? BURST_LEN'(1) : burst_sw;

    // Build the next lane image from the switches, plus the active-lane mux
    always_comb begin
        sw_sel    = '0;
        sel       = '0;
        addr_n    = '0;
        data_n    = '0;
        burst_n   = '0;
        slave_n   = '0;
        instr_n   = '0;
        lane_word = '0;
        lane_tx   = 1'b0;
        lane_rx   = 1'b0;
        lane_new  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sw_sel[i] = (master_sw == MSEL_LEN'(i));
            sel[i]    = (cmd_m == MSEL_LEN'(i));
            if (sw_sel[i]) begin
                addr_n[i*ADDR_LEN +: ADDR_LEN]    = addr_sw;
                data_n[i*DATA_LEN +: DATA_LEN]    = rw_sw ? '0 : data_sw;
                burst_n[i*BURST_LEN +: BURST_LEN] = burst_fix;
                slave_n[i*SLAVE_LEN +: SLAVE_LEN] = slave_sw;
                instr_n[2*i +: 2]                 = {1'b1, rw_sw};
            end
            if (sel[i]) begin
                lane_word = bus.new_data_m[i*DATA_LEN +: DATA_LEN];
                lane_tx   = bus.tx_done_m[i];
                lane_rx   = bus.rx_done_m[i];
                lane_new  = bus.new_rx_m[i];
            end
        end
    end

    assign lane_fin = (state == WRITE) ? lane_tx : lane_rx;

    // Command FSM with registered lane outputs and status
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cmd_m              <= '0;
            tcnt               <= '0;
            bus.address_m      <= '0;
            bus.data_m         <= '0;
            bus.burst_num_m    <= '0;
            bus.slave_select_m <= '0;
            bus.instruction_m  <= '0;
            read_data          <= '0;
            read_count         <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err_code           <= 2'b00;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go_pulse) begin
                        cmd_m      <= master_sw;
                        tcnt       <= '0;
                        read_count <= '0;
                        if (bad_sw) begin
                            err_code <= 2'b11;
                        end else begin
                            err_code           <= 2'b00;
                            state              <= rw_sw ? READ : WRITE;
                            busy               <= 1'b1;
                            bus.address_m      <= addr_n;
                            bus.data_m         <= data_n;
                            bus.burst_num_m    <= burst_n;
                            bus.slave_select_m <= slave_n;
                            bus.instruction_m  <= instr_n;
                        end
                    end
                end
                WRITE, READ: begin
                    if (state == READ && lane_new) begin
                        read_data <= lane_word;
                        if (read_count != '1)
                            read_count <= read_count + BURST_LEN'(1);
                    end
                    if (lane_fin || abort_pulse ||
                        tcnt == TW'(TIMEOUT - 2)) begin
                        state              <= IDLE;
                        busy               <= 1'b0;
                        bus.address_m      <= '0;
                        bus.data_m         <= '0;
                        bus.burst_num_m    <= '0;
                        bus.slave_select_m <= '0;
                        bus.instruction_m  <= '0;
                        if (lane_fin)
                            done <= 1'b1;
                        else if (abort_pulse)
                            err_code <= 2'b10;
                        else
                            err_code <= 2'b01;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
